// File: rtl/bp_me_bedrock_reg_bank.sv
// Single-beat BedRock memory-endpoint register bank.
// Each mem_fwd request is decoded against els_p wildcard base addresses. The bank pulses
// a per-register read or write strobe and returns a one-entry registered mem_rev response.
// The BedRock header is self-contained here. It is packed LSB first as
// {payload, size[2:0], addr, subop[3:0], msg_type[3:0]}.
// Optional checks: define BP_ME_BEDROCK_REG_BANK_CHECK_EN to enable simulation-only
// $error checks on unmatched, multiply-matched or non-read/write requests.
module bp_me_bedrock_reg_bank #(
  parameter int unsigned paddr_width_p        = 40,
  parameter int unsigned payload_width_p      = 16,
  parameter int unsigned bedrock_fill_width_p = 64,
  parameter int unsigned reg_data_width_p     = 64,
  parameter int unsigned reg_addr_width_p     = 20,
  parameter int unsigned els_p                = 1,
  // Element 0 is the LSB slice; X/Z bits are don't-care.
  parameter logic [els_p*reg_addr_width_p-1:0] base_addr_p = '0,
  localparam int unsigned size_width_lp = $clog2($clog2(reg_data_width_p/8)) + 1,
  localparam int unsigned mem_header_width_lp = 4 + 4 + paddr_width_p + 3 + payload_width_p
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [mem_header_width_lp-1:0]      mem_fwd_header_i,
  input  logic [bedrock_fill_width_p-1:0]     mem_fwd_data_i,
  input  logic                                mem_fwd_v_i,
  output logic                                mem_fwd_ready_and_o,
  output logic [mem_header_width_lp-1:0]      mem_rev_header_o,
  output logic [bedrock_fill_width_p-1:0]     mem_rev_data_o,
  output logic                                mem_rev_v_o,
  input  logic                                mem_rev_ready_and_i,
  output logic [els_p-1:0]                    r_v_o,
  output logic [els_p-1:0]                    w_v_o,
  output logic [reg_addr_width_p-1:0]         addr_o,
  output logic [size_width_lp-1:0]            size_o,
  output logic [reg_data_width_p-1:0]         data_o,
  input  logic [els_p*reg_data_width_p-1:0]   data_i
);

  localparam logic [3:0] e_bedrock_mem_rd    = 4'd0;
  localparam logic [3:0] e_bedrock_mem_wr    = 4'd1;
  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

  localparam int unsigned addr_lsb_lp    = 8;
  localparam int unsigned size_lsb_lp    = 8 + paddr_width_p;
  localparam int unsigned lg_reg_bytes_lp = $clog2(reg_data_width_p/8);
  localparam int unsigned idx_width_lp   = $clog2(reg_data_width_p);

  logic [3:0]                      fwd_msg_type;
  logic [2:0]                      fwd_size;
  logic [2:0]                      size_clamped;
  logic                            accept;
  logic                            is_rd;
  logic                            is_wr;
  logic [els_p-1:0]                match;
  logic [reg_data_width_p-1:0]     sel_data;
  logic [bedrock_fill_width_p-1:0] rep_data;
  logic [bedrock_fill_width_p-1:0] rev_data_next;

  assign fwd_msg_type = mem_fwd_header_i[3:0];
  assign fwd_size     = mem_fwd_header_i[size_lsb_lp +: 3];
  assign addr_o       = mem_fwd_header_i[addr_lsb_lp +: reg_addr_width_p];
  assign size_o       = size_width_lp'(fwd_size);
  assign data_o       = mem_fwd_data_i[reg_data_width_p-1:0];

  assign mem_fwd_ready_and_o = ~reset_i & (~mem_rev_v_o | mem_rev_ready_and_i);
  assign accept = mem_fwd_v_i & mem_fwd_ready_and_o;
  assign is_rd  = (fwd_msg_type == e_bedrock_mem_rd) | (fwd_msg_type == e_bedrock_mem_uc_rd);
  assign is_wr  = (fwd_msg_type == e_bedrock_mem_wr) | (fwd_msg_type == e_bedrock_mem_uc_wr);

  // Constant base per element so X/Z bits act as wildcards in ==?.
  for (genvar i = 0; i < els_p; i++) begin : g_match
    localparam logic [reg_addr_width_p-1:0] base_lp = base_addr_p[i*reg_addr_width_p +: reg_addr_width_p];
    assign match[i] = (addr_o ==? base_lp);
  end

  assign r_v_o = {els_p{accept & is_rd}} & match;
  assign w_v_o = {els_p{accept & is_wr}} & match;

  // Read source is the lowest matching register.
  always_comb begin
    sel_data = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (match[i]) sel_data = data_i[i*reg_data_width_p +: reg_data_width_p];
    end
  end

  // Replicate the low (8 << size) bits across the fill width; oversize requests clamp.
  always_comb begin
    size_clamped = (fwd_size > 3'(lg_reg_bytes_lp)) ? 3'(lg_reg_bytes_lp) : fwd_size;
    rep_data     = '0;
    for (int j = 0; j < int'(bedrock_fill_width_p); j++) begin
      rep_data[j] = sel_data[idx_width_lp'(j & ((8 << size_clamped) - 1))];
    end
    rev_data_next = (is_rd & (|match)) ? rep_data : '0;
  end

  // Single response register; holds under back-pressure, reloads on every accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_rev_v_o      <= 1'b0;
      mem_rev_header_o <= '0;
      mem_rev_data_o   <= '0;
    end else if (accept) begin
      mem_rev_v_o      <= 1'b1;
      mem_rev_header_o <= mem_fwd_header_i;
      mem_rev_data_o   <= rev_data_next;
    end else if (mem_rev_ready_and_i) begin
      mem_rev_v_o      <= 1'b0;
    end
  end

`ifdef BP_ME_BEDROCK_REG_BANK_CHECK_EN
  // Flag accepted requests that the bank cannot service cleanly.
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept) begin
      if (!(|match)) $error("reg_bank: access to unmapped address %h", addr_o);
      if ($countones(match) > 1) $error("reg_bank: address %h matches %b", addr_o, match);
      if (!(is_rd | is_wr)) $error("reg_bank: unsupported msg_type %0d", fwd_msg_type);
    end
  end
`else
  // Checks compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_bp_me_bedrock_reg_bank.sv
// Directed self-checking bench for bp_me_bedrock_reg_bank.
// It uses two registers: base[0]=0x00008 and base[1]=0x01??? (wildcard low 12 bits).
module tb_bp_me_bedrock_reg_bank;

  localparam logic [3:0] T_RD = 4'd0, T_WR = 4'd1, T_UC_RD = 4'd2, T_UC_WR = 4'd3, T_AMO = 4'd5;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [66:0]  mem_fwd_header_i;
  logic [63:0]  mem_fwd_data_i;
  logic         mem_fwd_v_i;
  logic         mem_fwd_ready_and_o;
  logic [66:0]  mem_rev_header_o;
  logic [63:0]  mem_rev_data_o;
  logic         mem_rev_v_o;
  logic         mem_rev_ready_and_i;
  logic [1:0]   r_v_o;
  logic [1:0]   w_v_o;
  logic [19:0]  addr_o;
  logic [2:0]   size_o;
  logic [63:0]  data_o;
  logic [127:0] data_i;

  int vectors = 0;
  int miscompares = 0;

  bp_me_bedrock_reg_bank #(
    .reg_data_width_p (64),
    .reg_addr_width_p (20),
    .els_p            (2),
    .base_addr_p      ({20'h0_1???, 20'h0_0008})
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .mem_fwd_header_i    (mem_fwd_header_i),
    .mem_fwd_data_i      (mem_fwd_data_i),
    .mem_fwd_v_i         (mem_fwd_v_i),
    .mem_fwd_ready_and_o (mem_fwd_ready_and_o),
    .mem_rev_header_o    (mem_rev_header_o),
    .mem_rev_data_o      (mem_rev_data_o),
    .mem_rev_v_o         (mem_rev_v_o),
    .mem_rev_ready_and_i (mem_rev_ready_and_i),
    .r_v_o               (r_v_o),
    .w_v_o               (w_v_o),
    .addr_o              (addr_o),
    .size_o              (size_o),
    .data_o              (data_o),
    .data_i              (data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] mk_hdr(input logic [3:0] t, input logic [39:0] a,
                                         input logic [2:0] s, input logic [15:0] p);
    return {p, s, a, 4'h0, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [66:0] h, input logic [63:0] d);
    mem_fwd_header_i = h;
    mem_fwd_data_i   = d;
    mem_fwd_v_i      = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({mem_rev_v_o, mem_fwd_ready_and_o, r_v_o, w_v_o, mem_rev_data_o} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got v=%b rdy=%b r=%b w=%b data=%h required all 0",
                 c, mem_rev_v_o, mem_fwd_ready_and_o, r_v_o, w_v_o, mem_rev_data_o);
      end
    end
    reset_i = 1'b0;
    #1;
    vectors++;
    if (mem_fwd_ready_and_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", mem_fwd_ready_and_o);
    end
  endtask

  task automatic test_uc_wr();
    logic [66:0] h;
    h = mk_hdr(T_UC_WR, 40'h0_1010, 3'd0, 16'hA5C3);
    drive(h, 64'h41);
    vectors++;
    if (w_v_o !== 2'b10 || r_v_o !== 2'b00) begin
      miscompares++;
      $display("FAIL uc_wr_strobe: got w=%b r=%b required w=10 r=00", w_v_o, r_v_o);
    end
    vectors++;
    if (addr_o !== 20'h01010 || data_o[7:0] !== 8'h41 || size_o !== 3'd0) begin
      miscompares++;
      $display("FAIL uc_wr_passthru: got addr=%h data=%h size=%0d required 01010 41 0",
               addr_o, data_o[7:0], size_o);
    end
    tick();
    mem_fwd_v_i = 1'b0;
    vectors++;
    if (mem_rev_v_o !== 1'b1 || mem_rev_data_o !== 64'h0 || mem_rev_header_o !== h) begin
      miscompares++;
      $display("FAIL uc_wr_resp: got v=%b data=%h hdr=%h required 1 0 %h",
               mem_rev_v_o, mem_rev_data_o, mem_rev_header_o, h);
    end
    tick();
    vectors++;
    if (mem_rev_v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL uc_wr_resp_clear: got v=%b required 0", mem_rev_v_o);
    end
  endtask

  task automatic test_uc_rd();
    data_i[63:0] = 64'hDEAD_BEEF_0123_4567;
    drive(mk_hdr(T_UC_RD, 40'h0_0008, 3'd3, 16'h0), 64'h0);
    vectors++;
    if (r_v_o !== 2'b01 || w_v_o !== 2'b00) begin
      miscompares++;
      $display("FAIL uc_rd_strobe: got r=%b w=%b required r=01 w=00", r_v_o, w_v_o);
    end
    tick();
    // Device may update data after the accept edge; response must not follow it.
    data_i[63:0] = 64'h0;
    mem_fwd_v_i = 1'b0;
    #1;
    vectors++;
    if (mem_rev_v_o !== 1'b1 || mem_rev_data_o !== 64'hDEAD_BEEF_0123_4567) begin
      miscompares++;
      $display("FAIL uc_rd_data: got v=%b data=%h required 1 deadbeef01234567",
               mem_rev_v_o, mem_rev_data_o);
    end
  endtask

  task automatic test_replicate();
    data_i[63:0] = 64'h1111_2222_3333_445A;
    drive(mk_hdr(T_UC_RD, 40'h0_0008, 3'd0, 16'h0), 64'h0);
    tick();
    vectors++;
    if (mem_rev_data_o !== 64'h5A5A_5A5A_5A5A_5A5A) begin
      miscompares++;
      $display("FAIL rd_size0_repl: got %h required 5a5a5a5a5a5a5a5a", mem_rev_data_o);
    end
    // Cached read, size 1, from the wildcard register.
    data_i[127:64] = 64'h9999_8888_7777_BEEF;
    drive(mk_hdr(T_RD, 40'h0_1FF0, 3'd1, 16'h0), 64'h0);
    vectors++;
    if (r_v_o !== 2'b10 || mem_fwd_ready_and_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_size1_strobe: got r=%b rdy=%b required r=10 rdy=1",
               r_v_o, mem_fwd_ready_and_o);
    end
    tick();
    vectors++;
    if (mem_rev_data_o !== 64'hBEEF_BEEF_BEEF_BEEF) begin
      miscompares++;
      $display("FAIL rd_size1_repl: got %h required beefbeefbeefbeef", mem_rev_data_o);
    end
    // Oversized request clamps to 64 bits.
    data_i[63:0] = 64'hFEDC_BA98_7654_3210;
    drive(mk_hdr(T_RD, 40'h0_0008, 3'd6, 16'h0), 64'h0);
    vectors++;
    if (size_o !== 3'd6) begin
      miscompares++;
      $display("FAIL size_passthru: got %0d required 6", size_o);
    end
    tick();
    mem_fwd_v_i = 1'b0;
    vectors++;
    if (mem_rev_data_o !== 64'hFEDC_BA98_7654_3210) begin
      miscompares++;
      $display("FAIL size_clamp: got %h required fedcba9876543210", mem_rev_data_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [66:0] h2;
    mem_rev_ready_and_i = 1'b0;
    data_i[127:64] = 64'h1122_3344_5566_7788;
    drive(mk_hdr(T_UC_RD, 40'h0_1234, 3'd3, 16'h0), 64'h0);
    tick();
    // Second request waits while the response is stalled.
    h2 = mk_hdr(T_UC_RD, 40'h0_0008, 3'd2, 16'h7777);
    data_i[127:64] = 64'h0;
    data_i[63:0]   = 64'h0123_4567_89AB_CDEF;
    drive(h2, 64'h0);
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (mem_rev_v_o !== 1'b1 || mem_rev_data_o !== 64'h1122_3344_5566_7788 ||
          mem_fwd_ready_and_o !== 1'b0 || r_v_o !== 2'b00) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: got v=%b data=%h rdy=%b r=%b required 1 1122334455667788 0 00",
                 c, mem_rev_v_o, mem_rev_data_o, mem_fwd_ready_and_o, r_v_o);
      end
      if (c < 3) tick();
    end
    tick();
    mem_rev_ready_and_i = 1'b1;
    #1;
    vectors++;
    if (mem_fwd_ready_and_o !== 1'b1 || r_v_o !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_release: got rdy=%b r=%b required 1 01", mem_fwd_ready_and_o, r_v_o);
    end
    tick();
    mem_fwd_v_i = 1'b0;
    vectors++;
    if (mem_rev_v_o !== 1'b1 || mem_rev_data_o !== 64'h89AB_CDEF_89AB_CDEF ||
        mem_rev_header_o !== h2) begin
      miscompares++;
      $display("FAIL stall_second_resp: got v=%b data=%h hdr=%h required 1 89abcdef89abcdef %h",
               mem_rev_v_o, mem_rev_data_o, mem_rev_header_o, h2);
    end
    tick();
  endtask

  task automatic test_unmapped();
    data_i = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    drive(mk_hdr(T_UC_WR, 40'h0_2000, 3'd3, 16'h0), 64'hFF);
    vectors++;
    if (r_v_o !== 2'b00 || w_v_o !== 2'b00) begin
      miscompares++;
      $display("FAIL unmapped_wr_strobe: got r=%b w=%b required 00 00", r_v_o, w_v_o);
    end
    tick();
    drive(mk_hdr(T_UC_RD, 40'h0_0010, 3'd3, 16'h0), 64'h0);
    vectors++;
    if (mem_rev_v_o !== 1'b1 || mem_rev_data_o !== 64'h0) begin
      miscompares++;
      $display("FAIL unmapped_wr_resp: got v=%b data=%h required 1 0", mem_rev_v_o, mem_rev_data_o);
    end
    tick();
    drive(mk_hdr(T_AMO, 40'h0_0008, 3'd3, 16'h0), 64'h0);
    vectors++;
    if (mem_rev_data_o !== 64'h0 || r_v_o !== 2'b00 || w_v_o !== 2'b00) begin
      miscompares++;
      $display("FAIL unmapped_rd_resp/amo_strobe: got data=%h r=%b w=%b required 0 00 00",
               mem_rev_data_o, r_v_o, w_v_o);
    end
    tick();
    mem_fwd_v_i = 1'b0;
    vectors++;
    if (mem_rev_v_o !== 1'b1 || mem_rev_data_o !== 64'h0) begin
      miscompares++;
      $display("FAIL amo_resp: got v=%b data=%h required 1 0", mem_rev_v_o, mem_rev_data_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mem_rev_ready_and_i = 1'b0;
    drive(mk_hdr(T_WR, 40'h0_0008, 3'd3, 16'h0), 64'h1234);
    vectors++;
    if (w_v_o !== 2'b01) begin
      miscompares++;
      $display("FAIL cached_wr_strobe: got %b required 01", w_v_o);
    end
    tick();
    mem_fwd_v_i = 1'b0;
    reset_i = 1'b1;
    tick();
    vectors++;
    if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b rdy=%b required 0 0", mem_rev_v_o, mem_fwd_ready_and_o);
    end
    reset_i = 1'b0;
    mem_rev_ready_and_i = 1'b1;
    #1;
    vectors++;
    if (mem_fwd_ready_and_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_release: got rdy=%b required 1", mem_fwd_ready_and_o);
    end
  endtask

  initial begin
    reset_i             = 1'b1;
    mem_fwd_header_i    = '0;
    mem_fwd_data_i      = '0;
    mem_fwd_v_i         = 1'b0;
    mem_rev_ready_and_i = 1'b1;
    data_i              = '0;
    test_reset();
    test_uc_wr();
    test_uc_rd();
    test_replicate();
    test_backpressure();
    test_unmapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
